my_serdes_tx: RTL and testbench
===============================

MY_SERDES_TX -- requirements
Module: my_serdes_tx

Interface
REQ-001 The block SHALL have parameter BASE, default 8'd0, the settings-bus address of the control register.
REQ-002 The block SHALL have port dsp_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port dsp_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have ports set_stb input 1, set_addr input 8 and set_data input 32: the settings-bus write.
REQ-005 The block SHALL have port rx_data, input, 32 bits: the data word offered by the guarded source.
REQ-006 The block SHALL have port rx_flags, input, 4 bits: bit0 is SOP, bit1 is EOP, and bits 3:2 are ignored.
REQ-007 The block SHALL have port rx_pop_rdy, input, 1 bit: the source holds a valid word.
REQ-008 The block SHALL have port rx_pop_en, output, 1 bit: pop strobe that consumes the word in the same cycle.
REQ-009 The block SHALL have port ser_t, output, 16 bits: the SERDES transmit halfword.
REQ-010 The block SHALL have ports ser_tklsb and ser_tkmsb, outputs, 1 bit each: K-char flags for ser_t[7:0] and ser_t[15:8].
REQ-011 The block SHALL have port drop_count, output, 8 bits: count of words discarded outside a packet.
REQ-012 The block SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-013 The block SHALL have port debug, output, 32 bits: {state, ctrl, drop_count, 16'b0}.

Function
REQ-014 A write with set_stb=1 and set_addr==BASE SHALL load ctrl <= set_data[0]; ctrl is the enable bit.
REQ-015 ser_t, ser_tklsb and ser_tkmsb SHALL be registered; each state emits one symbol in the cycle after it is entered.
REQ-016 The state machine SHALL have the states IDLE, SOS, LO, HI, WAIT, CHK and EOP.
REQ-017 IDLE and WAIT SHALL emit 16'hC5BC with tklsb=1 and tkmsb=0.
REQ-018 SOS SHALL emit 16'h5C5C and EOP SHALL emit 16'hFDFD, each with k=11.
REQ-019 LO SHALL emit word[15:0] and HI SHALL emit word[31:16], each with k=00.
REQ-020 rx_pop_en SHALL equal rx_pop_rdy && ((IDLE && ctrl) || (HI && !cur_eop) || WAIT) and be combinational.
REQ-021 A pop SHALL register rx_data into word and rx_flags[1] into cur_eop.
REQ-022 In IDLE, a pop with SOP=1 SHALL go to SOS then LO; a pop with SOP=0 SHALL discard the word, stay in IDLE and saturate-increment drop_count at 255.
REQ-023 From HI, cur_eop=1 SHALL go to CHK (macro on) or EOP (macro off); EOP then goes to IDLE.
REQ-024 From HI with cur_eop=0, a pop SHALL go to LO, otherwise the state SHALL go to WAIT.
REQ-025 From WAIT, a pop SHALL go to LO, otherwise the state SHALL remain in WAIT.
REQ-026 Throughput SHALL be one 32-bit word per 2 cycles with no gap when rx_pop_rdy stays high.
REQ-027 A SOP flag on a mid-packet word SHALL be ignored.
REQ-028 Clearing ctrl mid-packet SHALL not abort the packet; ctrl is sampled only in IDLE.
REQ-029 A settings write coincident with a pop SHALL take effect on the next cycle.

Reset
REQ-030 dsp_rst SHALL force immediately: state=IDLE, ctrl=0, drop_count=0, word=0, cur_eop=0, csum=0.
REQ-031 While dsp_rst is asserted, ser_t SHALL be 16'hC5BC with tklsb=1 and tkmsb=0, and rx_pop_en and busy SHALL be 0.
REQ-032 A reset mid-packet SHALL truncate the packet with no EOP sent.

Configuration
REQ-033 With MY_SERDES_TX_CHECKSUM_EN defined, csum SHALL clear on SOS and add each LO/HI halfword mod 2^16.
REQ-034 With MY_SERDES_TX_CHECKSUM_EN defined, CHK SHALL emit csum with k=00 between the last HI and EOP.
REQ-035 With MY_SERDES_TX_CHECKSUM_EN undefined, the CHK state and csum logic SHALL be absent and HI SHALL go directly to EOP.

Structure
REQ-036 Package my_serdes_pkg SHALL hold K_COMMA=8'hBC, D_56=8'hC5, K_SOS=8'h5C, K_EOP=8'hFD, the state encoding and the flag bit indices; the receiver shares the package.
REQ-037 The checksum accumulator SHALL be the sub-module my_serdes_tx_csum (clear, add_en, din[15:0], sum[15:0]).

Verification
REQ-038 Reset, then idle with no writes -> ser_t=16'hC5BC k=01 indefinitely and rx_pop_en=0 even with rx_pop_rdy=1.
REQ-039 Write set_addr=BASE, set_data=1, then send 32'hDEADBEEF with flags 4'b0011 -> 5C5C/11, BEEF/00, DEAD/00, [9D9C/00 if CSUM], FDFD/11, then C5BC/01.
REQ-040 Send 3 words 11111111, 22222222 and 33333333 (SOP on the first, EOP on the last) with rdy held high -> rx_pop_en pulses only in IDLE then in HI cycles, and the 6 data symbols are contiguous.
REQ-041 Drop rx_pop_rdy for 2 cycles after the first word's HI -> two C5BC/01 WAIT symbols, then LO of word 2, and busy=1 throughout.
REQ-042 With ctrl=1, send 300 non-SOP words in IDLE -> all are popped and nothing is emitted but C5BC, with drop_count = 1 after the first and 255 at the end.
REQ-043 Assert dsp_rst asynchronously during HI -> the outputs show C5BC/01 before the next clock edge, and ctrl=0 and drop_count=0 after release.

Source files
------------

// File: rtl/my_serdes_pkg.sv
// Shared definitions for the SERDES framing transmitter and its receiver.
// Holds the 8b/10b control/data characters, the framer state encoding,
// the rx_flags bit positions and the transmit symbol payload type.
package my_serdes_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] D_56    = 8'hC5;
  localparam logic [7:0] K_SOS   = 8'h5C;
  localparam logic [7:0] K_EOP   = 8'hFD;

  localparam int unsigned FLAG_SOP = 0;
  localparam int unsigned FLAG_EOP = 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SOS  = 3'd1,
    LO   = 3'd2,
    HI   = 3'd3,
    WAIT = 3'd4,
    CHK  = 3'd5,
    EOP  = 3'd6
  } state_e;

  // One transmit halfword with its per-byte K-character flags.
  typedef struct packed {
    logic [HALF_W-1:0] data;
    logic              k_msb;
    logic              k_lsb;
  } sym_t;

  localparam sym_t SYM_IDLE = '{data: {D_56, K_COMMA}, k_msb: 1'b0, k_lsb: 1'b1};
  localparam sym_t SYM_SOS  = '{data: {K_SOS, K_SOS},  k_msb: 1'b1, k_lsb: 1'b1};
  localparam sym_t SYM_EOP  = '{data: {K_EOP, K_EOP},  k_msb: 1'b1, k_lsb: 1'b1};

  // Plain data halfword, no K flags.
  function automatic sym_t data_sym(input logic [HALF_W-1:0] d);
    sym_t s;
    s.data  = d;
    s.k_msb = 1'b0;
    s.k_lsb = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/my_serdes_tx_csum.sv
// Running 16-bit checksum of transmitted payload halfwords.
// Only built when MY_SERDES_TX_CHECKSUM_EN is defined.
// Ports: clk, rst (async, active-high), clear (zero the sum, wins over add),
//        add_en (accumulate din), din[15:0], sum[15:0] (registered sum).
`ifdef MY_SERDES_TX_CHECKSUM_EN
module my_serdes_tx_csum
  import my_serdes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [HALF_W-1:0] din,
  output logic [HALF_W-1:0] sum
);

  logic [HALF_W-1:0] sum_q, sum_d;

  // Sum wraps modulo 2^16.
  always_comb begin
    sum_d = sum_q;
    if (clear) begin
      sum_d = '0;
    end else if (add_en) begin
      sum_d = sum_q + din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum = sum_q;

endmodule
`endif

// File: rtl/my_serdes_tx.sv
// Packet framer: pops 32-bit words from a guarded source and sends them as
// 16-bit SERDES symbols framed by SOS/EOP K-characters, idling on C5BC.
// Words popped outside a packet without SOP are dropped and counted.
// Optional: MY_SERDES_TX_CHECKSUM_EN adds a checksum symbol before EOP.
// Ports: dsp_clk/dsp_rst (async active-high); set_stb/set_addr/set_data
//        settings write (ctrl enable at BASE); rx_data/rx_flags/rx_pop_rdy
//        source, rx_pop_en combinational pop strobe; ser_t/ser_tklsb/
//        ser_tkmsb registered symbol; drop_count, busy, debug status.
module my_serdes_tx
  import my_serdes_pkg::*;
#(
  parameter logic [7:0] BASE = 8'd0
) (
  input  logic              dsp_clk,
  input  logic              dsp_rst,
  input  logic              set_stb,
  input  logic [7:0]        set_addr,
  input  logic [31:0]       set_data,
  input  logic [WORD_W-1:0] rx_data,
  input  logic [3:0]        rx_flags,
  input  logic              rx_pop_rdy,
  output logic              rx_pop_en,
  output logic [HALF_W-1:0] ser_t,
  output logic              ser_tklsb,
  output logic              ser_tkmsb,
  output logic [7:0]        drop_count,
  output logic              busy,
  output logic [31:0]       debug
);

  state_e            state_q, state_d;
  logic              ctrl_q, ctrl_d;
  logic [7:0]        drop_q, drop_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              cur_eop_q, cur_eop_d;
  sym_t              sym_q, sym_d;
  logic              pop;

  // ctrl only gates the start of a packet; mid-packet pops ignore it.
  assign pop = rx_pop_rdy &&
               (((state_q == IDLE) && ctrl_q) ||
                ((state_q == HI) && !cur_eop_q) ||
                (state_q == WAIT));

`ifdef MY_SERDES_TX_CHECKSUM_EN
  logic [HALF_W-1:0] csum;

  my_serdes_tx_csum u_csum (
    .clk    (dsp_clk),
    .rst    (dsp_rst),
    .clear  (state_q == SOS),
    .add_en ((state_q == LO) || (state_q == HI)),
    .din    ((state_q == HI) ? word_q[WORD_W-1:HALF_W] : word_q[HALF_W-1:0]),
    .sum    (csum)
  );
`endif

  // Next state, datapath and the symbol of the current state.
  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    drop_d    = drop_q;
    word_d    = word_q;
    cur_eop_d = cur_eop_q;
    sym_d     = SYM_IDLE;

    if (set_stb && (set_addr == BASE)) begin
      ctrl_d = set_data[0];
    end

    if (pop) begin
      word_d    = rx_data;
      cur_eop_d = rx_flags[FLAG_EOP];
    end

    case (state_q)
      IDLE: begin
        sym_d = SYM_IDLE;
        if (pop) begin
          if (rx_flags[FLAG_SOP]) begin
            state_d = SOS;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      SOS: begin
        sym_d   = SYM_SOS;
        state_d = LO;
      end
      LO: begin
        sym_d   = data_sym(word_q[HALF_W-1:0]);
        state_d = HI;
      end
      HI: begin
        sym_d = data_sym(word_q[WORD_W-1:HALF_W]);
        if (cur_eop_q) begin
`ifdef MY_SERDES_TX_CHECKSUM_EN
          state_d = CHK;
`else
          state_d = EOP;
`endif
        end else if (pop) begin
          state_d = LO;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        sym_d = SYM_IDLE;
        if (pop) begin
          state_d = LO;
        end
      end
`ifdef MY_SERDES_TX_CHECKSUM_EN
      CHK: begin
        sym_d   = data_sym(csum);
        state_d = EOP;
      end
`endif
      EOP: begin
        sym_d   = SYM_EOP;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge dsp_clk or posedge dsp_rst) begin
    if (dsp_rst) begin
      state_q   <= IDLE;
      ctrl_q    <= 1'b0;
      drop_q    <= '0;
      word_q    <= '0;
      cur_eop_q <= 1'b0;
      sym_q     <= SYM_IDLE;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      drop_q    <= drop_d;
      word_q    <= word_d;
      cur_eop_q <= cur_eop_d;
      sym_q     <= sym_d;
    end
  end

  assign rx_pop_en  = pop;
  assign ser_t      = sym_q.data;
  assign ser_tklsb  = sym_q.k_lsb;
  assign ser_tkmsb  = sym_q.k_msb;
  assign drop_count = drop_q;
  assign busy       = (state_q != IDLE);
  assign debug      = {7'(state_q), ctrl_q, drop_q, 16'h0000};

  // Only set_data[0] and the SOP/EOP flags carry meaning.
  logic unused_bits;
  assign unused_bits = ^{set_data[31:1], rx_flags[3:2]};

endmodule

// File: tb/tb_my_serdes_tx.sv
// Scoreboard bench for my_serdes_tx: packets are described at word level,
// expected symbol streams are queued, and a monitor checks every symbol.
module tb_my_serdes_tx;

  localparam logic [7:0] BASE = 8'h40;

  logic        dsp_clk = 1'b0;
  logic        dsp_rst;
  logic        set_stb;
  logic [7:0]  set_addr;
  logic [31:0] set_data;
  logic [31:0] rx_data;
  logic [3:0]  rx_flags;
  logic        rx_pop_rdy;
  logic        rx_pop_en;
  logic [15:0] ser_t;
  logic        ser_tklsb;
  logic        ser_tkmsb;
  logic [7:0]  drop_count;
  logic        busy;
  logic [31:0] debug;

  my_serdes_tx #(.BASE(BASE)) dut (
    .dsp_clk    (dsp_clk),
    .dsp_rst    (dsp_rst),
    .set_stb    (set_stb),
    .set_addr   (set_addr),
    .set_data   (set_data),
    .rx_data    (rx_data),
    .rx_flags   (rx_flags),
    .rx_pop_rdy (rx_pop_rdy),
    .rx_pop_en  (rx_pop_en),
    .ser_t      (ser_t),
    .ser_tklsb  (ser_tklsb),
    .ser_tkmsb  (ser_tkmsb),
    .drop_count (drop_count),
    .busy       (busy),
    .debug      (debug)
  );

  always #5 dsp_clk = ~dsp_clk;

  typedef struct { logic [15:0] d; logic [1:0] k; } sym_s;
  typedef struct { logic [31:0] data; logic [3:0] flags; int gap; } src_s;

  sym_s        exp_q[$];
  src_s        src_q[$];
  logic [31:0] pkt_w[$];
  int          pop_cyc[$];
  int          compared = 0;
  int          mismatched = 0;
  int          cyc = 0;
  int          pops = 0;
  int          gap_cnt = 0;
  bit          in_pkt = 1'b0;
  int          exp_drop = 0;

  always @(posedge dsp_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] d, input logic [1:0] k);
    sym_s s;
    s.d = d;
    s.k = k;
    exp_q.push_back(s);
  endtask

  task automatic push_src(input logic [31:0] d, input logic [3:0] f, input int g);
    src_s s;
    s.data  = d;
    s.flags = f;
    s.gap   = g;
    src_q.push_back(s);
  endtask

  // Packet from pkt_w; gap = idle-rdy cycles before each word is offered.
  task automatic push_pkt(input int g_first, input int g_mid, input bit rnd);
    logic [15:0] cs;
    logic [1:0]  hi_bits;
    logic        sop;
    int          n;
    cs = 16'h0000;
    n  = pkt_w.size();
    push_exp(16'h5C5C, 2'b11);
    for (int i = 0; i < n; i++) begin
      hi_bits = rnd ? 2'($urandom_range(0, 3)) : 2'b00;
      sop     = (i == 0) ? 1'b1 : (rnd ? 1'($urandom_range(0, 1)) : 1'b0);
      push_src(pkt_w[i], {hi_bits, (i == n - 1), sop}, (i == 0) ? g_first : g_mid);
      push_exp(pkt_w[i][15:0], 2'b00);
      push_exp(pkt_w[i][31:16], 2'b00);
      cs = cs + pkt_w[i][15:0] + pkt_w[i][31:16];
    end
`ifdef MY_SERDES_TX_CHECKSUM_EN
    push_exp(cs, 2'b00);
`endif
    push_exp(16'hFDFD, 2'b11);
  endtask

  // Words without SOP offered between packets: dropped and counted.
  task automatic push_junk(input int n, input int g);
    for (int i = 0; i < n; i++) begin
      push_src($urandom, {2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0}, g);
      exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    end
  endtask

  task automatic sett(input logic [7:0] a, input logic [31:0] d);
    @(negedge dsp_clk);
    set_stb  = 1'b1;
    set_addr = a;
    set_data = d;
    @(negedge dsp_clk);
    set_stb  = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int t;
    t = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || busy) && t < budget) begin
      @(negedge dsp_clk);
      t++;
    end
    if (t >= budget) begin
      compared++;
      mismatched++;
      $display("FAIL %s: timeout with %0d words and %0d symbols pending", name, src_q.size(), exp_q.size());
    end
    repeat (2) @(negedge dsp_clk);
  endtask

  // Source: offers the queue head after its gap, consumes it on rx_pop_en.
  initial begin : source
    rx_pop_rdy = 1'b0;
    rx_data    = '0;
    rx_flags   = '0;
    forever begin
      @(negedge dsp_clk);
      if (src_q.size() == 0) begin
        rx_pop_rdy = 1'b0;
      end else if (src_q[0].gap > 0) begin
        rx_pop_rdy    = 1'b0;
        src_q[0].gap  = src_q[0].gap - 1;
      end else begin
        rx_pop_rdy = 1'b1;
        rx_data    = src_q[0].data;
        rx_flags   = src_q[0].flags;
      end
      #1;
      if (rx_pop_en) begin
        if (src_q.size() > 0) void'(src_q.pop_front());
        pop_cyc.push_back(cyc);
        pops++;
      end
    end
  end

  // Monitor: every non-idle symbol must match the scoreboard head.
  initial begin : monitor
    sym_s       e;
    logic [1:0] k;
    forever begin
      @(negedge dsp_clk);
      if (!dsp_rst) begin
        k = {ser_tkmsb, ser_tklsb};
        if (k == 2'b01) begin
          check("idle_sym", 32'(ser_t), 32'h0000C5BC);
          if (in_pkt) begin
            gap_cnt++;
            check("busy_in_gap", 32'(busy), 32'd1);
          end
        end else begin
          if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_sym: got %h/%b expected none", ser_t, k);
          end else begin
            e = exp_q.pop_front();
            check("sym", {14'(0), k, ser_t}, {14'(0), e.k, e.d});
          end
          if (k == 2'b11 && ser_t == 16'h5C5C) in_pkt = 1'b1;
          if (k == 2'b11 && ser_t == 16'hFDFD) in_pkt = 1'b0;
        end
      end
    end
  end

  initial begin : main
    int t;
    int p0;
    dsp_rst  = 1'b1;
    set_stb  = 1'b0;
    set_addr = '0;
    set_data = '0;
    repeat (3) @(negedge dsp_clk);
    check("rst_ser", 32'(ser_t), 32'h0000C5BC);
    check("rst_k", {30'(0), ser_tkmsb, ser_tklsb}, 32'd1);
    check("rst_pop_en", 32'(rx_pop_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_debug", debug, 32'd0);
    dsp_rst = 1'b0;

    // ctrl=0: a ready source must not be popped.
    pkt_w = {32'hDEADBEEF};
    push_pkt(0, 0, 1'b0);
    repeat (5) begin
      @(negedge dsp_clk);
      #2;
      check("no_pop_ctrl0", 32'(rx_pop_en), 32'd0);
    end
    sett(BASE + 8'd1, 32'd1);
    check("wrong_addr_ctrl", 32'(debug[24]), 32'd0);
    check("pops_before_en", 32'(pops), 32'd0);
    sett(BASE, 32'd1);
    check("ctrl_set", 32'(debug[24]), 32'd1);
    drain("deadbeef", 200);
    check("pops_deadbeef", 32'(pops), 32'd1);

    // Back-to-back words: pops at IDLE then every HI, no gaps.
    gap_cnt = 0;
    pop_cyc.delete();
    pkt_w = {32'h11111111, 32'h22222222, 32'h33333333};
    push_pkt(0, 0, 1'b0);
    drain("three_words", 200);
    check("contig_gaps", 32'(gap_cnt), 32'd0);
    check("contig_pops", 32'(pop_cyc.size()), 32'd3);
    if (pop_cyc.size() == 3) begin
      check("pop_spacing0", 32'(pop_cyc[1] - pop_cyc[0]), 32'd3);
      check("pop_spacing1", 32'(pop_cyc[2] - pop_cyc[1]), 32'd2);
    end

    // Source stalls after the first word's HI: two WAIT symbols.
    gap_cnt = 0;
    pkt_w = {32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3};
    push_pkt(0, 4, 1'b0);
    src_q[src_q.size() - 1].gap = 0;
    drain("wait_gap", 200);
    check("wait_gaps", 32'(gap_cnt), 32'd2);

    // Drop counting and saturation.
    p0 = pops;
    push_junk(1, 0);
    drain("drop1", 100);
    check("drop_first", 32'(drop_count), 32'd1);
    push_junk(299, 0);
    drain("drop300", 2000);
    check("drop_sat", 32'(drop_count), 32'd255);
    check("drop_debug", 32'(debug[23:16]), 32'd255);
    check("drop_pops", 32'(pops - p0), 32'd300);

    // Clearing ctrl mid-packet does not abort it.
    pkt_w = {32'h01020304, 32'h05060708, 32'h090A0B0C};
    push_pkt(0, 2, 1'b1);
    t = 0;
    while (!in_pkt && t < 50) begin
      @(negedge dsp_clk);
      t++;
    end
    check("pkt_started", 32'(in_pkt), 32'd1);
    sett(BASE, 32'd0);
    drain("ctrl_clear", 200);
    check("ctrl_cleared", 32'(debug[24]), 32'd0);

    // Asynchronous reset while in HI.
    sett(BASE, 32'd1);
    pkt_w = {32'hA5A51234, 32'h5A5A6789, 32'h0BADF00D};
    push_pkt(0, 0, 1'b0);
    t = 0;
    do begin
      @(negedge dsp_clk);
      #2;
      t++;
    end while (!(ser_t == 16'h1234 && {ser_tkmsb, ser_tklsb} == 2'b00) && t < 50);
    check("reached_hi", 32'(t < 50), 32'd1);
    dsp_rst = 1'b1;
    #1;
    check("async_ser", 32'(ser_t), 32'h0000C5BC);
    check("async_k", {30'(0), ser_tkmsb, ser_tklsb}, 32'd1);
    check("async_pop_en", 32'(rx_pop_en), 32'd0);
    check("async_busy", 32'(busy), 32'd0);
    src_q.delete();
    exp_q.delete();
    in_pkt = 1'b0;
    repeat (2) @(negedge dsp_clk);
    dsp_rst = 1'b0;
    @(negedge dsp_clk);
    check("post_rst_ctrl", 32'(debug[24]), 32'd0);
    check("post_rst_drop", 32'(drop_count), 32'd0);
    exp_drop = 0;

    // Randomized traffic with junk words and random source stalls.
    sett(BASE, 32'd1);
    for (int i = 0; i < 25; i++) begin
      push_junk($urandom_range(0, 2), $urandom_range(0, 3));
      pkt_w.delete();
      for (int j = 0; j < $urandom_range(1, 4); j++) pkt_w.push_back($urandom);
      push_pkt($urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
    end
    drain("random", 5000);
    check("random_drop", 32'(drop_count), 32'(exp_drop));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
